// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - loader, fetch and memory-port bundle for instr_fetch_ctrl
// Ports (master = controller side):
//   loader : load_start, load_valid, load_data, load_done in; load_ready out
//   control: start, stall, branch_taken, branch_target, instr_in in
//   memory : pc, mem_we, mem_waddr, mem_wdata out
//   status : state, halted, cycle_count out
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [DATA_W-1:0] instr_in;
    logic [31:0]       pc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        state;
    logic              halted;
    logic [31:0]       cycle_count;

    modport master (
        input  load_start, load_valid, load_data, load_done,
        input  start, stall, branch_taken, branch_target, instr_in,
        output load_ready, pc, mem_we, mem_waddr, mem_wdata,
        output state, halted, cycle_count
    );

    modport slave (
        output load_start, load_valid, load_data, load_done,
        output start, stall, branch_taken, branch_target, instr_in,
        input  load_ready, pc, mem_we, mem_waddr, mem_wdata,
        input  state, halted, cycle_count
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction memory sequencer: loader writes, PC fetch, HALT detect
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - instr_fetch_ctrl_if.master (loader handshake, fetch control, memory port, status)
module instr_fetch_ctrl #(
    parameter int         ADDR_W  = 5,
    parameter int         DATA_W  = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input logic             clk,
    input logic             reset,
    instr_fetch_ctrl_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] wr_ptr;
    // One bit wider than the address so a full memory (2^ADDR_W words) is representable.
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       cycle_cnt;
    logic              accept;
    logic              is_halt;

    // Bits that are deliberately dropped: upper branch target and the instruction operand field.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.branch_target[31:ADDR_W], bus.instr_in[DATA_W-7:0]};

    assign bus.load_ready  = (state_r == ST_LOAD) && !word_cnt[ADDR_W];
    assign accept          = bus.load_ready && bus.load_valid;
    assign bus.mem_we      = accept;
    assign bus.mem_waddr   = wr_ptr;
    assign bus.mem_wdata   = bus.load_data;
    assign bus.pc          = {{(32-ADDR_W){1'b0}}, pc_r};
    assign bus.state       = state_r;
    assign bus.halted      = (state_r == ST_HALT);
    assign bus.cycle_count = cycle_cnt;
    assign is_halt         = (bus.instr_in[DATA_W-1:DATA_W-6] == HALT_OP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= '0;
            wr_ptr    <= '0;
            word_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        state_r  <= ST_LOAD;
                        wr_ptr   <= '0;
                        word_cnt <= '0;
                    end else if (bus.start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= '0;
                        cycle_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    // A restart pulse rewinds the pointer; otherwise an accepted word advances it.
                    if (bus.load_start) begin
                        wr_ptr   <= '0;
                        word_cnt <= '0;
                    end else if (accept) begin
                        wr_ptr   <= wr_ptr + ADDR_W'(1);
                        word_cnt <= word_cnt + (ADDR_W+1)'(1);
                    end
                    if (bus.load_done) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cycle_cnt != 32'hFFFF_FFFF) begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                    end
                    if (bus.load_start) begin
                        state_r  <= ST_LOAD;
                        wr_ptr   <= '0;
                        word_cnt <= '0;
                    end else if (bus.branch_taken) begin
                        pc_r <= bus.branch_target[ADDR_W-1:0];
                    end else if (bus.stall) begin
                        pc_r <= pc_r;
                    end else if (is_halt) begin
                        state_r <= ST_HALT;
                    end else begin
                        pc_r <= pc_r + ADDR_W'(1);
                    end
                end
                default: begin
                    if (bus.load_start) begin
                        state_r  <= ST_LOAD;
                        wr_ptr   <= '0;
                        word_cnt <= '0;
                    end else if (bus.start) begin
                        state_r   <= ST_RUN;
                        pc_r      <= '0;
                        cycle_cnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed table-driven bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
    typedef struct {
        logic        rst, ls, lv, ld, st, stl, br;
        logic [31:0] bt, data;
        logic        e_we, e_rdy;
        logic [4:0]  e_waddr;
        logic [1:0]  e_state;
        logic [31:0] e_pc, e_cc;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] mem [0:31];
    logic [4:0]  wlog [$];
    vec_t        vecs [$];

    instr_fetch_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    instr_fetch_ctrl #(.ADDR_W(5), .DATA_W(32), .HALT_OP(6'b111111)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.instr_in = mem[bus.pc[4:0]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
            wlog.push_back(bus.mem_waddr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_done = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    endtask

    function automatic vec_t v(input logic rst, ls, lv, ld, st, stl, br,
                               input logic [31:0] bt, data,
                               input logic we, rdy, input logic [4:0] wa,
                               input logic [1:0] s, input logic [31:0] p, cc);
        vec_t r;
        r.rst = rst; r.ls = ls; r.lv = lv; r.ld = ld; r.st = st; r.stl = stl; r.br = br;
        r.bt = bt; r.data = data; r.e_we = we; r.e_rdy = rdy; r.e_waddr = wa;
        r.e_state = s; r.e_pc = p; r.e_cc = cc;
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_pc", bus.pc, 32'd0);
        chk("reset_cc", bus.cycle_count, 32'd0);
        chk("reset_ready", 32'(bus.load_ready), 32'd0);
        chk("reset_we", 32'(bus.mem_we), 32'd0);
        chk("reset_halted", 32'(bus.halted), 32'd0);

        // Load 8 words, then load_done.
        wlog.delete();
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        chk("t1_state_load", 32'(bus.state), 32'd1);
        chk("t1_ready", 32'(bus.load_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            bus.load_valid = 1'b1; bus.load_data = 32'hA000_0000 | 32'(k);
            tick();
        end
        bus.load_valid = 1'b0; bus.load_done = 1'b1; tick(); bus.load_done = 1'b0;
        chk("t1_nwrites", 32'(wlog.size()), 32'd8);
        for (int k = 0; k < 8 && k < wlog.size(); k++) chk("t1_waddr", 32'(wlog[k]), 32'(k));
        chk("t1_state_idle", 32'(bus.state), 32'd0);
        chk("t1_pc", bus.pc, 32'd0);
        chk("t1_mem7", mem[7], 32'hA000_0007);

        // 40 offered words, only 32 stored.
        wlog.delete();
        bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus.load_valid = 1'b1; bus.load_data = 32'hB000_0000 | 32'(k);
            #3;
            if (k == 31) chk("t2_ready_31", 32'(bus.load_ready), 32'd1);
            if (k == 32) chk("t2_ready_32", 32'(bus.load_ready), 32'd0);
            if (k == 39) chk("t2_we_39", 32'(bus.mem_we), 32'd0);
            tick();
        end
        bus.load_valid = 1'b0; bus.load_done = 1'b1; tick(); bus.load_done = 1'b0;
        chk("t2_nwrites", 32'(wlog.size()), 32'd32);
        if (wlog.size() >= 32) chk("t2_last_addr", 32'(wlog[31]), 32'd31);
        chk("t2_mem0", mem[0], 32'hB000_0000);
        chk("t2_mem31", mem[31], 32'hB000_001F);
        chk("t2_state_idle", 32'(bus.state), 32'd0);

        // Free run over the wrap.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("t3_state_run", 32'(bus.state), 32'd2);
        chk("t3_cc0", bus.cycle_count, 32'd0);
        for (int i = 0; i < 35; i++) begin
            #3;
            chk("t3_pc_seq", bus.pc, 32'(i % 32));
            tick();
        end
        chk("t3_cc35", bus.cycle_count, 32'd35);
        chk("t3_pc_end", bus.pc, 32'd3);

        // Table: stall/branch, reload with HALT, halt/restart, resets mid-RUN and mid-LOAD.
        //             rst ls lv ld st stl br  bt          data           we rdy wa  st  pc   cc
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,          0,             0, 0, 0,  0,  0,   0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,          0,             0, 0, 0,  2,  0,   0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0,             0, 0, 0,  2,  32'(i), 32'(i)));
        for (int i = 6; i <= 8; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,      0,             0, 0, 0,  2,  5,   32'(i)));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 1, 32'h34,     0,             0, 0, 0,  2,  20,  9));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0,          0,             0, 0, 0,  1,  20,  10));
        for (int k = 0; k < 8; k++)
            vecs.push_back(v(0, 0, 1, (k == 7), 0, 0, 0, 0,
                             (k == 7) ? 32'hFC00_0000 : (32'hC000_0000 | 32'(k)),
                             1, 1, 5'(k), (k == 7) ? 2'd0 : 2'd1, 20, 10));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,          0,             0, 0, 0,  2,  0,   0));
        for (int i = 1; i <= 7; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0,             0, 0, 0,  2,  32'(i), 32'(i)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,      0,             0, 0, 0,  3,  7,   8));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,          0,             0, 0, 0,  2,  0,   0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 12,         0,             0, 0, 0,  2,  12,  1));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0,          0,             0, 0, 0,  0,  0,   0));
        vecs.push_back(v(0, 1, 0, 0, 1, 0, 0, 0,          0,             0, 0, 0,  1,  0,   0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0,      32'hD000_0000 | 32'(k), 1, 1, 5'(k), 1, 0, 0));
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 0, 0,          32'hD000_0003, 1, 1, 3,  0,  0,   0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 0,          32'hD000_0004, 0, 0, 0,  0,  0,   0));

        foreach (vecs[n]) begin
            reset = vecs[n].rst;
            bus.load_start = vecs[n].ls; bus.load_valid = vecs[n].lv; bus.load_data = vecs[n].data;
            bus.load_done = vecs[n].ld; bus.start = vecs[n].st; bus.stall = vecs[n].stl;
            bus.branch_taken = vecs[n].br; bus.branch_target = vecs[n].bt;
            #3;
            chk($sformatf("v%0d_we", n), 32'(bus.mem_we), 32'(vecs[n].e_we));
            chk($sformatf("v%0d_ready", n), 32'(bus.load_ready), 32'(vecs[n].e_rdy));
            if (vecs[n].e_we) chk($sformatf("v%0d_waddr", n), 32'(bus.mem_waddr), 32'(vecs[n].e_waddr));
            tick();
            chk($sformatf("v%0d_state", n), 32'(bus.state), 32'(vecs[n].e_state));
            chk($sformatf("v%0d_pc", n), bus.pc, vecs[n].e_pc);
            chk($sformatf("v%0d_cc", n), bus.cycle_count, vecs[n].e_cc);
            chk($sformatf("v%0d_halted", n), 32'(bus.halted), 32'(vecs[n].e_state == 2'd3));
        end
        idle_inputs();
        chk("halt_word_stored", mem[7], 32'hFC00_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequencer for the instruction memory. It owns the program counter and shares the memory between two users: a program loader, which writes words sequentially through a valid/ready handshake, and the pipeline fetch stage, which reads one word per cycle. It sits between the debug/loader unit, the IF stage and the instruction memory, and drives the memory address and write port. It also detects the HALT opcode and counts execution cycles.

Parameters:
ADDR_W, 5, word-address width of the instruction memory (depth 2^ADDR_W = 32 words)
DATA_W, 32, instruction width
HALT_OP, 6'b111111, opcode in bits [31:26] that stops execution

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  pulse; enter LOAD and rewind the write pointer
load_valid  in  1  loader offers load_data
load_data  in  DATA_W  instruction word to store
load_ready  out  1  controller can accept a word this cycle
load_done  in  1  pulse; loader has finished
start  in  1  pulse; begin execution from address 0
stall  in  1  hazard unit holds the PC
branch_taken  in  1  redirect the PC
branch_target  in  32  word address of the redirect
instr_in  in  DATA_W  word currently read from memory at pc
pc  out  32  word address to the instruction memory; upper 32-ADDR_W bits always 0
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
state  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
halted  out  1  high while state==HALT
cycle_count  out  32  rising edges spent in RUN since the last start

Behaviour:
- Reset (synchronous, high): state=IDLE, pc=0, wr_ptr=0, word_cnt=0, cycle_count=0. With those values, load_ready=0, mem_we=0 and halted=0. Reset overrides every other input on the same edge, including reset in the middle of LOAD or RUN. Memory contents are not cleared.
- IDLE:
  - load_start -> LOAD, with wr_ptr=0 and word_cnt=0.
  - otherwise start -> RUN, with pc=0 and cycle_count=0.
  - load_start and start together: load_start wins.
- LOAD:
  - load_ready = (word_cnt < 2^ADDR_W).
  - Accept condition: load_valid & load_ready, evaluated in the same cycle. On accept, mem_we=1, mem_waddr=wr_ptr, mem_wdata=load_data, all combinational. The memory writes on that edge; wr_ptr and word_cnt then increment.
  - After 32 words, load_ready=0 and further load_valid is ignored. No wrap, no overwrite.
  - load_done -> IDLE. A word accepted in the same cycle as load_done is still written.
  - start is ignored in LOAD.
  - pc holds its value during LOAD.
- RUN, priority order per edge:
  1. branch_taken: pc = branch_target[ADDR_W-1:0]. Branch wins over stall and over halt detection.
  2. stall: pc holds.
  3. instr_in[31:26]==HALT_OP: pc holds, next state HALT.
  4. Otherwise pc = (pc+1) mod 2^ADDR_W, so 31 wraps to 0.
  - cycle_count increments on every RUN edge and saturates at 32'hFFFFFFFF.
  - load_start in RUN: abort execution and go to LOAD, with wr_ptr=0 and word_cnt=0.
  - start in RUN: ignored.
  - mem_we=0 and load_ready=0 throughout RUN.
- HALT:
  - pc and cycle_count hold.
  - start -> RUN with pc=0 and cycle_count=0.
  - load_start -> LOAD; it wins if asserted together with start.
- Memory read is combinational: instr_in corresponds to the current pc in the same cycle. Fetch latency is zero cycles from the pc update.
- branch_target bits above ADDR_W are silently discarded.
- mem_we is never asserted outside LOAD.

Test Plan:
1. Load 8 words (pattern 32'hA000_000k), load_valid held high, then load_done -> mem_we high for exactly 8 cycles, mem_waddr 0..7, state returns to IDLE, pc=0.
2. load_valid held high for 40 cycles in LOAD -> exactly 32 writes (addresses 0..31); load_ready drops after the 32nd; address 0 is not rewritten.
3. start with no halt in memory, 35 cycles -> pc goes 0,1,…,31,0,1,2; cycle_count=35.
4. RUN at pc=5 with stall=1 for 3 cycles, then branch_taken=1 with stall=1 and branch_target=32'h0000_0034 -> pc holds at 5 for the three stall cycles, then becomes 20 (0x34 mod 32).
5. instr_in=32'hFC00_0000 at pc=7 -> next cycle state=HALT, halted=1, pc stays 7 and cycle_count stops; a later start sets pc=0, state=RUN, cycle_count=0.
6. Reset asserted mid-LOAD after 3 writes, and separately mid-RUN at pc=12 -> next edge state=IDLE, pc=0, load_ready=0, mem_we=0, cycle_count=0; load_start and start in the same IDLE cycle -> state=LOAD.
